// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - issue/result bundle between the E stage and the multiply/divide unit
//
// Signals:
//   start  - E-stage instruction is an MDU op
//   op     - 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 MADD
//   A, B   - rs / rt operands after forwarding
//   cancel - E-stage instruction is being flushed this cycle
//   busy   - a multiply/divide is in flight
//   stall  - combinational stall request to the hazard unit
//   HI, LO - architectural HI/LO registers
// master: pipeline side (drives the request); slave: the unit itself.
interface mul_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        cancel;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, op, A, B, cancel, input busy, stall, HI, LO);
   modport slave  (input start, op, A, B, cancel, output busy, stall, HI, LO);
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MIPS-style multiply/divide unit with HI/LO registers
//
// Ports:
//   clk   - pipeline clock, rising edge
//   reset - synchronous, active-high; clears HI/LO and aborts any operation
//   mdu   - mul_div_unit_if.slave: start/op/A/B/cancel in, busy/stall/HI/LO out
// Multiplies (and MADD) take 5 busy cycles, divides take 10; MTHI/MTLO write in one edge.
// Build option: define MDU_MADD_EN to enable op 111 (MADD); otherwise op 111 is a no-op.
module mul_div_unit (
   input  logic         clk,
   input  logic         reset,
   mul_div_unit_if.slave mdu
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
`ifdef MDU_MADD_EN
   localparam logic [2:0] OP_MADD  = 3'b111;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

   state_t      state_q, state_d;
   logic [3:0]  count_q;
   logic [2:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi_q, lo_q;

   logic        busy;
   logic        is_mul_op, is_div_op, accept, done;

   always_comb begin
      is_mul_op = (mdu.op == OP_MULT) || (mdu.op == OP_MULTU);
`ifdef MDU_MADD_EN
      if (mdu.op == OP_MADD)
         is_mul_op = 1'b1;
`endif
      is_div_op = (mdu.op == OP_DIV) || (mdu.op == OP_DIVU);
   end

   assign accept = mdu.start & ~busy & ~mdu.cancel;
   // Counter is loaded with the latency and the result lands on the edge it would hit 0.
   assign done   = (state_q != ST_IDLE) && (count_q == 4'd1);

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && is_mul_op)
               state_d = ST_MUL;
            else if (accept && is_div_op)
               state_d = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            if (done)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      busy      = (state_q != ST_IDLE);
      mdu.busy  = busy;
      // Stall is raised on the issue cycle too, before the op has been accepted.
      mdu.stall = busy | (mdu.start & (is_mul_op | is_div_op));
   end

   // ---- datapath ----
   logic [63:0] prod_s, prod_u, result;
   logic        res_we;
   logic        div_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // Signed divide on magnitudes; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
   assign div_signed = (op_q == OP_DIV);
   assign a_neg      = div_signed & a_q[31];
   assign b_neg      = div_signed & b_q[31];
   assign a_mag      = a_neg ? -a_q : a_q;
   assign b_mag      = b_neg ? -b_q : b_q;
   assign q_mag      = a_mag / b_mag;
   assign r_mag      = a_mag % b_mag;
   assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign rem        = a_neg ? -r_mag : r_mag;

   always_comb begin
      result = {hi_q, lo_q};
      res_we = 1'b0;
      case (op_q)
         OP_MULT:  begin result = prod_s; res_we = 1'b1; end
         OP_MULTU: begin result = prod_u; res_we = 1'b1; end
         OP_DIV, OP_DIVU: begin
            // Divide by zero burns the full latency but leaves HI/LO alone.
            result = {rem, quot};
            res_we = (b_q != 32'd0);
         end
`ifdef MDU_MADD_EN
         OP_MADD:  begin result = {hi_q, lo_q} + prod_s; res_we = 1'b1; end
`endif
         default:  begin result = {hi_q, lo_q}; res_we = 1'b0; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 4'd0;
         op_q    <= 3'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         if (accept && (is_mul_op || is_div_op)) begin
            count_q <= is_div_op ? 4'd10 : 4'd5;
            op_q    <= mdu.op;
            a_q     <= mdu.A;
            b_q     <= mdu.B;
         end else if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
         end

         // Completion only happens while busy and moves only while idle, so they never collide.
         if (done && res_we) begin
            hi_q <= result[63:32];
            lo_q <= result[31:0];
         end else if (accept && mdu.op == OP_MTHI) begin
            hi_q <= mdu.A;
         end else if (accept && mdu.op == OP_MTLO) begin
            lo_q <= mdu.A;
         end
      end
   end

   assign mdu.HI = hi_q;
   assign mdu.LO = lo_q;

endmodule
